// File: rtl/fc_ctrl.sv
// Sequencer for the FC1 (800->500) and FC2 (500->10) layers: walks feature
// and weight SRAMs, frames MAC terms and writes result bytes to e0-e4 / f.
module fc_ctrl #(
    parameter int FC1_K      = 40,
    parameter int FC1_N      = 500,
    parameter int FC2_K      = 25,
    parameter int FC2_N      = 10,
    parameter int FC2_W_BASE = 20000
) (
    input  logic        clk,
    input  logic        srstn,
    input  logic        conv_done,
    input  logic        mem_sel,
    input  logic        res_valid,
    input  logic [7:0]  res_data,
    output logic [9:0]  sram_raddr_cd,
    output logic [9:0]  sram_raddr_e,
    output logic [14:0] sram_raddr_weight,
    output logic [1:0]  rd_src,
    output logic        acc_en,
    output logic        acc_first,
    output logic        acc_last,
    output logic        sram_write_enable_e0,
    output logic        sram_write_enable_e1,
    output logic        sram_write_enable_e2,
    output logic        sram_write_enable_e3,
    output logic        sram_write_enable_e4,
    output logic        sram_write_enable_f,
    output logic [3:0]  sram_bytemask_e,
    output logic [3:0]  sram_bytemask_f,
    output logic [9:0]  sram_waddr_e,
    output logic [9:0]  sram_waddr_f,
    output logic [7:0]  sram_wdata_e,
    output logic [7:0]  sram_wdata_f,
    output logic        fc1_done,
    output logic        fc2_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FC1_RD,
        S_FC1_WAIT,
        S_FC2_RD,
        S_FC2_WAIT
    } state_t;

    localparam logic [5:0]  K1_LAST = 6'(FC1_K - 1);
    localparam logic [5:0]  K2_LAST = 6'(FC2_K - 1);
    localparam logic [8:0]  N1_LAST = 9'(FC1_N - 1);
    localparam logic [8:0]  N2_LAST = 9'(FC2_N - 1);
    localparam logic [8:0]  N1_CNT  = 9'(FC1_N);
    localparam logic [8:0]  N2_CNT  = 9'(FC2_N);
    localparam logic [14:0] W2_BASE = 15'(FC2_W_BASE);

    state_t      r_state;
    state_t      w_state_nx;
    logic [5:0]  r_k;
    logic [8:0]  r_n;
    logic [14:0] r_wptr;
    logic        r_sel;

    logic        r_iss;
    logic        r_iss_first;
    logic        r_iss_last;
    logic [1:0]  r_src_iss;
    logic [9:0]  r_raddr_cd;
    logic [9:0]  r_raddr_e;
    logic [14:0] r_raddr_w;
    logic        r_acc_en;
    logic        r_acc_first;
    logic        r_acc_last;
    logic [1:0]  r_rd_src;

    logic [8:0]  r_rc;
    logic [2:0]  r_bank;
    logic [4:0]  r_row;
    logic [4:0]  r_we_e;
    logic        r_we_f;
    logic [3:0]  r_bm_e;
    logic [3:0]  r_bm_f;
    logic [9:0]  r_waddr_e;
    logic [9:0]  r_waddr_f;
    logic [7:0]  r_wdata_e;
    logic [7:0]  r_wdata_f;
    logic        r_fc1_done;
    logic        r_fc2_done;

    logic        w_start;
    logic        w_fc2;
    logic        w_iss;
    logic        w_k_last;
    logic        w_n_last;
    logic        w_rd_end;
    logic        w_wr1;
    logic        w_wr2;
    logic        w_wr1_last;
    logic        w_wr2_last;
    logic [1:0]  w_src;
    logic [3:0]  w_mask;

    assign w_start  = (r_state == S_IDLE) && conv_done;
    assign w_fc2    = (r_state == S_FC2_RD);
    assign w_iss    = w_start || (r_state == S_FC1_RD) || w_fc2;
    assign w_k_last = w_fc2 ? (r_k == K2_LAST) : (r_k == K1_LAST);
    assign w_n_last = w_fc2 ? (r_n == N2_LAST) : (r_n == N1_LAST);
    assign w_rd_end = w_iss && w_k_last && w_n_last;

    assign w_wr1 = res_valid && (r_rc < N1_CNT)
                && ((r_state == S_FC1_RD) || (r_state == S_FC1_WAIT));
    assign w_wr2 = res_valid && (r_rc < N2_CNT)
                && ((r_state == S_FC2_RD) || (r_state == S_FC2_WAIT));
    assign w_wr1_last = w_wr1 && (r_rc == N1_LAST);
    assign w_wr2_last = w_wr2 && (r_rc == N2_LAST);

    // mem_sel is latched at start, so the start cycle uses the live pin
    assign w_src  = w_fc2   ? 2'd2
                  : w_start ? {1'b0, !mem_sel}
                  :           {1'b0, !r_sel};
    assign w_mask = ~(4'b1000 >> r_rc[1:0]);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:
                if (conv_done) w_state_nx = S_FC1_RD;
            S_FC1_RD:
                if (w_wr1_last)    w_state_nx = S_FC2_RD;
                else if (w_rd_end) w_state_nx = S_FC1_WAIT;
            S_FC1_WAIT:
                if (w_wr1_last) w_state_nx = S_FC2_RD;
            S_FC2_RD:
                if (w_wr2_last)    w_state_nx = S_IDLE;
                else if (w_rd_end) w_state_nx = S_FC2_WAIT;
            S_FC2_WAIT:
                if (w_wr2_last) w_state_nx = S_IDLE;
            default:
                w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_n     <= '0;
            r_wptr  <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) r_sel <= mem_sel;
            if (w_wr1_last) begin
                r_k    <= '0;
                r_n    <= '0;
                r_wptr <= W2_BASE;
            end else if (w_wr2_last) begin
                r_k    <= '0;
                r_n    <= '0;
                r_wptr <= '0;
            end else if (w_iss) begin
                r_k    <= w_k_last ? 6'd0 : r_k + 6'd1;
                r_n    <= w_k_last ? r_n + 9'd1 : r_n;
                r_wptr <= r_wptr + 15'd1;
            end
        end
    end

    // Issue stage drives addresses; the acc flags follow one cycle later
    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_iss       <= 1'b0;
            r_iss_first <= 1'b0;
            r_iss_last  <= 1'b0;
            r_src_iss   <= 2'd0;
            r_raddr_cd  <= '0;
            r_raddr_e   <= '0;
            r_raddr_w   <= '0;
            r_acc_en    <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc_last  <= 1'b0;
            r_rd_src    <= 2'd0;
        end else begin
            r_iss <= w_iss;
            if (w_iss) begin
                r_iss_first <= (r_k == 6'd0);
                r_iss_last  <= w_k_last;
                r_src_iss   <= w_src;
                r_raddr_w   <= r_wptr;
                if (w_fc2) r_raddr_e  <= {4'd0, r_k};
                else       r_raddr_cd <= {4'd0, r_k};
            end
            r_acc_en    <= r_iss;
            r_acc_first <= r_iss && r_iss_first;
            r_acc_last  <= r_iss && r_iss_last;
            r_rd_src    <= r_src_iss;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_rc       <= '0;
            r_bank     <= '0;
            r_row      <= '0;
            r_we_e     <= 5'h1F;
            r_we_f     <= 1'b1;
            r_bm_e     <= 4'hF;
            r_bm_f     <= 4'hF;
            r_waddr_e  <= '0;
            r_waddr_f  <= '0;
            r_wdata_e  <= '0;
            r_wdata_f  <= '0;
            r_fc1_done <= 1'b0;
            r_fc2_done <= 1'b0;
        end else begin
            r_we_e     <= 5'h1F;
            r_we_f     <= 1'b1;
            r_bm_e     <= 4'hF;
            r_bm_f     <= 4'hF;
            r_fc1_done <= 1'b0;
            r_fc2_done <= 1'b0;
            if (w_wr1) begin
                r_we_e    <= ~(5'd1 << r_bank);
                r_bm_e    <= w_mask;
                r_waddr_e <= {5'd0, r_row};
                r_wdata_e <= res_data;
                r_rc      <= r_rc + 9'd1;
                if (r_rc[1:0] == 2'd3) begin
                    r_bank <= (r_bank == 3'd4) ? 3'd0 : r_bank + 3'd1;
                    r_row  <= (r_bank == 3'd4) ? r_row + 5'd1 : r_row;
                end
                if (w_wr1_last) begin
                    r_fc1_done <= 1'b1;
                    r_rc       <= '0;
                    r_bank     <= '0;
                    r_row      <= '0;
                end
            end
            if (w_wr2) begin
                r_we_f    <= 1'b0;
                r_bm_f    <= w_mask;
                r_waddr_f <= {3'd0, r_rc[8:2]};
                r_wdata_f <= res_data;
                r_rc      <= r_rc + 9'd1;
                if (w_wr2_last) begin
                    r_fc2_done <= 1'b1;
                    r_rc       <= '0;
                end
            end
        end
    end

    assign sram_raddr_cd        = r_raddr_cd;
    assign sram_raddr_e         = r_raddr_e;
    assign sram_raddr_weight    = r_raddr_w;
    assign rd_src               = r_rd_src;
    assign acc_en               = r_acc_en;
    assign acc_first            = r_acc_first;
    assign acc_last             = r_acc_last;
    assign sram_write_enable_e0 = r_we_e[0];
    assign sram_write_enable_e1 = r_we_e[1];
    assign sram_write_enable_e2 = r_we_e[2];
    assign sram_write_enable_e3 = r_we_e[3];
    assign sram_write_enable_e4 = r_we_e[4];
    assign sram_write_enable_f  = r_we_f;
    assign sram_bytemask_e      = r_bm_e;
    assign sram_bytemask_f      = r_bm_f;
    assign sram_waddr_e         = r_waddr_e;
    assign sram_waddr_f         = r_waddr_f;
    assign sram_wdata_e         = r_wdata_e;
    assign sram_wdata_f         = r_wdata_f;
    assign fc1_done             = r_fc1_done;
    assign fc2_done             = r_fc2_done;
    assign busy                 = (r_state != S_IDLE) || r_fc2_done;

endmodule

// File: tb/tb_fc_ctrl.sv
// Scoreboard bench for fc_ctrl: term-sequence model, echoing datapath and
// expected-write queue compared against the observed SRAM write port.
module tb_fc_ctrl;

    localparam int FC1_K = 40;
    localparam int FC1_N = 500;
    localparam int FC2_K = 25;
    localparam int FC2_N = 10;
    localparam int W2B   = 20000;

    logic        clk;
    logic        srstn;
    logic        conv_done;
    logic        mem_sel;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [9:0]  sram_raddr_cd;
    logic [9:0]  sram_raddr_e;
    logic [14:0] sram_raddr_weight;
    logic [1:0]  rd_src;
    logic        acc_en;
    logic        acc_first;
    logic        acc_last;
    logic        we_e0, we_e1, we_e2, we_e3, we_e4, we_f;
    logic [3:0]  sram_bytemask_e;
    logic [3:0]  sram_bytemask_f;
    logic [9:0]  sram_waddr_e;
    logic [9:0]  sram_waddr_f;
    logic [7:0]  sram_wdata_e;
    logic [7:0]  sram_wdata_f;
    logic        fc1_done;
    logic        fc2_done;
    logic        busy;
    logic [4:0]  we_e;

    assign we_e = {we_e4, we_e3, we_e2, we_e1, we_e0};

    fc_ctrl dut (
        .clk                  (clk),
        .srstn                (srstn),
        .conv_done            (conv_done),
        .mem_sel              (mem_sel),
        .res_valid            (res_valid),
        .res_data             (res_data),
        .sram_raddr_cd        (sram_raddr_cd),
        .sram_raddr_e         (sram_raddr_e),
        .sram_raddr_weight    (sram_raddr_weight),
        .rd_src               (rd_src),
        .acc_en               (acc_en),
        .acc_first            (acc_first),
        .acc_last             (acc_last),
        .sram_write_enable_e0 (we_e0),
        .sram_write_enable_e1 (we_e1),
        .sram_write_enable_e2 (we_e2),
        .sram_write_enable_e3 (we_e3),
        .sram_write_enable_e4 (we_e4),
        .sram_write_enable_f  (we_f),
        .sram_bytemask_e      (sram_bytemask_e),
        .sram_bytemask_f      (sram_bytemask_f),
        .sram_waddr_e         (sram_waddr_e),
        .sram_waddr_f         (sram_waddr_f),
        .sram_wdata_e         (sram_wdata_e),
        .sram_wdata_f         (sram_wdata_f),
        .fc1_done             (fc1_done),
        .fc2_done             (fc2_done),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int mk, mn, mlayer, nacc, nwr1, nwr2, nfc1, nfc2;
    int rr, rlayer, nlast, last_due, lat_mode;
    logic model_sel;
    int due_q[$];
    logic [24:0] exp_q[$];
    logic [9:0]  p_cd, p_e;
    logic [14:0] p_w;
    logic [31:0] img_e [0:124];
    logic [31:0] img_f [0:3];
    logic [31:0] snap_e [0:124];
    logic [31:0] snap_f [0:3];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        mk = 0; mn = 0; mlayer = 0; nacc = 0;
        nwr1 = 0; nwr2 = 0; nfc1 = 0; nfc2 = 0;
        rr = 0; rlayer = 0; nlast = 0; last_due = 0;
        due_q.delete();
        exp_q.delete();
        for (int i = 0; i < 125; i++) img_e[i] = '0;
        for (int i = 0; i < 4; i++) img_f[i] = '0;
    endtask

    task automatic monitor();
        int kk, nlow, bank, idx, d;
        logic [1:0]  es;
        logic [14:0] ew;
        logic [24:0] ow, xw;
        logic [3:0]  m;
        logic [7:0]  dat;
        if (srstn) begin
            if (acc_en) begin
                kk = (mlayer != 0) ? FC2_K : FC1_K;
                es = (mlayer != 0) ? 2'd2 : (model_sel ? 2'd0 : 2'd1);
                ew = (mlayer != 0) ? 15'(W2B + mn * FC2_K + mk)
                                   : 15'(mn * FC1_K + mk);
                chk("acc_term",
                    {35'd0, rd_src, acc_first, acc_last,
                     (mlayer != 0) ? p_e : p_cd, p_w},
                    {35'd0, es, 1'(mk == 0), 1'(mk == kk - 1),
                     10'(mk), ew});
                nacc++;
                if (acc_last) begin
                    d = cyc + ((lat_mode == 0) ? 3 : ((nlast % 2 != 0) ? 7 : 1));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    nlast++;
                    due_q.push_back(d);
                end
                mk++;
                if (mk == kk) begin
                    mk = 0;
                    mn++;
                    if (mlayer == 0 && mn == FC1_N) begin
                        mlayer = 1;
                        mn = 0;
                    end
                end
            end
            nlow = $countones(~we_e) + (we_f ? 0 : 1);
            if (nlow != 0) begin
                chk("we_onehot", 64'(nlow), 64'(1));
                bank = 0;
                for (int b = 0; b < 5; b++) if (!we_e[b]) bank = b;
                if (!we_f) begin
                    ow  = {3'd5, sram_waddr_f, sram_bytemask_f, sram_wdata_f};
                    m   = sram_bytemask_f;
                    dat = sram_wdata_f;
                    idx = int'(sram_waddr_f);
                    nwr2++;
                end else begin
                    ow  = {3'(bank), sram_waddr_e, sram_bytemask_e, sram_wdata_e};
                    m   = sram_bytemask_e;
                    dat = sram_wdata_e;
                    idx = bank * 25 + int'(sram_waddr_e);
                    nwr1++;
                end
                if (exp_q.size() == 0) begin
                    chk("write_spurious", 64'(nlow), 64'(0));
                end else begin
                    xw = exp_q.pop_front();
                    chk("write", 64'(ow), 64'(xw));
                end
                for (int b = 0; b < 4; b++) begin
                    if (!m[3-b]) begin
                        if (!we_f && idx < 4) img_f[idx][31-8*b -: 8] = dat;
                        if (we_f && idx < 125) img_e[idx][31-8*b -: 8] = dat;
                    end
                end
            end
            if (fc1_done) begin
                nfc1++;
                chk("fc1_done_on_last_write", 64'(nwr1), 64'(FC1_N));
            end
            if (fc2_done) begin
                nfc2++;
                chk("fc2_done_on_last_write", 64'(nwr2), 64'(FC2_N));
                chk("busy_in_fc2_done", 64'(busy), 64'(1));
            end
        end
        p_cd = sram_raddr_cd;
        p_e  = sram_raddr_e;
        p_w  = sram_raddr_weight;
    endtask

    task automatic respond();
        int w;
        logic [3:0] m;
        res_valid = 1'b0;
        if (!srstn) return;
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            res_valid = 1'b1;
            res_data  = 8'(rr);
            w = rr / 4;
            m = 4'hF;
            m[3 - (rr % 4)] = 1'b0;
            if (rlayer == 0) exp_q.push_back({3'(w % 5), 10'(w / 5), m, 8'(rr)});
            else             exp_q.push_back({3'd5, 10'(w), m, 8'(rr)});
            rr++;
            if (rlayer == 0 && rr == FC1_N) begin
                rlayer = 1;
                rr = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        respond();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_raddr"},
            64'({sram_raddr_cd, sram_raddr_e, sram_raddr_weight}), 64'(0));
        chk({tag, "_acc"}, 64'({rd_src, acc_en, acc_first, acc_last}), 64'(0));
        chk({tag, "_we"}, 64'({we_e, we_f}), 64'(6'h3F));
        chk({tag, "_mask"}, 64'({sram_bytemask_e, sram_bytemask_f}), 64'(8'hFF));
        chk({tag, "_waddr_wdata"},
            64'({sram_waddr_e, sram_waddr_f, sram_wdata_e, sram_wdata_f}),
            64'(0));
        chk({tag, "_done_busy"}, 64'({fc1_done, fc2_done, busy}), 64'(0));
    endtask

    task automatic start_run(input logic sel, input int mode);
        clear_model();
        lat_mode  = mode;
        model_sel = sel;
        mem_sel   = sel;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk("start_raddr", 64'({sram_raddr_cd, sram_raddr_weight}), 64'(0));
        chk("start_busy_acc", 64'({busy, acc_en}), 64'(2'b10));
        tick();
        chk("start_acc_first", 64'({acc_en, acc_first}), 64'(2'b11));
    endtask

    task automatic stray_and_finish(input logic sel);
        int b;
        repeat (3000) tick();
        conv_done = 1'b1;
        mem_sel   = !sel;
        tick();
        conv_done = 1'b0;
        b = 0;
        while (nfc2 == 0 && b < 25000) begin
            tick();
            b++;
        end
        if (nfc2 == 0) chk("fc2_done_timeout", 64'(nfc2), 64'(1));
        tick();
        chk("busy_after_fc2", 64'(busy), 64'(0));
        chk("idle_we_mask",
            64'({we_e, we_f, sram_bytemask_e, sram_bytemask_f}),
            64'({6'h3F, 8'hFF}));
        chk("acc_terms", 64'(nacc), 64'(FC1_N * FC1_K + FC2_N * FC2_K));
        chk("fc1_writes", 64'(nwr1), 64'(FC1_N));
        chk("fc2_writes", 64'(nwr2), 64'(FC2_N));
        chk("done_pulses", 64'({nfc1[7:0], nfc2[7:0]}), 64'(16'h0101));
        chk("queues_drained", 64'(exp_q.size() + due_q.size()), 64'(0));
    endtask

    task automatic compare_image(input string tag);
        int m = 0;
        for (int i = 0; i < 125; i++) if (img_e[i] !== snap_e[i]) m++;
        for (int i = 0; i < 4; i++) if (img_f[i] !== snap_f[i]) m++;
        chk(tag, 64'(m), 64'(0));
    endtask

    initial begin
        srstn     = 1'b0;
        conv_done = 1'b0;
        mem_sel   = 1'b0;
        res_valid = 1'b0;
        res_data  = 8'd0;
        lat_mode  = 0;
        model_sel = 1'b0;
        clear_model();
        repeat (3) tick();
        check_reset_state("reset");
        res_valid = 1'b1;
        srstn = 1'b1;
        tick();
        chk("idle_ignores_res_valid", 64'({we_e, we_f}), 64'(6'h3F));
        res_valid = 1'b0;
        tick();

        start_run(1'b1, 0);
        stray_and_finish(1'b1);
        chk("img_res0_e0_a0", 64'(img_e[0]), 64'(32'h00010203));
        chk("img_res4_e1_a0", 64'(img_e[25]), 64'(32'h04050607));
        chk("img_res499_e4_a24", 64'(img_e[4*25+24]), 64'(32'hF0F1F2F3));
        chk("img_f_a2", 64'(img_f[2]), 64'(32'h08090000));
        for (int i = 0; i < 125; i++) snap_e[i] = img_e[i];
        for (int i = 0; i < 4; i++) snap_f[i] = img_f[i];

        start_run(1'b0, 1);
        stray_and_finish(1'b0);
        compare_image("image_var_latency");

        start_run(1'b1, 0);
        repeat (5000) tick();
        srstn = 1'b0;
        tick();
        check_reset_state("midrun_reset");
        chk("midrun_no_fc1_done", 64'(nfc1), 64'(0));
        tick();
        srstn = 1'b1;
        clear_model();
        repeat (4) tick();
        chk("midrun_idle", 64'({busy, acc_en, we_e, we_f}), 64'(8'h3F));
        start_run(1'b1, 0);
        stray_and_finish(1'b1);
        compare_image("image_after_restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
